// File: rtl/memory_writeback_skid_register.sv
// MEM/WB pipeline register with a two-entry skid buffer.
// Registered ready, flush, x0 write suppression and write-back data mux.
module memory_writeback_skid_register #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      flush,
    input  logic                      inValid,
    output logic                      inReady,
    input  logic                      writeBackFromMemoryOrAlu,
    input  logic [DATA_WIDTH-1:0]     memoryReadData,
    input  logic [DATA_WIDTH-1:0]     aluData,
    input  logic [REG_ADDR_WIDTH-1:0] destinationRegister,
    input  logic                      registerWriteEnable,
    output logic                      outValid,
    input  logic                      outReady,
    output logic                      writeBackFromMemoryOrAluOut,
    output logic [DATA_WIDTH-1:0]     memoryReadDataOut,
    output logic [DATA_WIDTH-1:0]     aluDataOut,
    output logic [DATA_WIDTH-1:0]     writeBackDataOut,
    output logic [REG_ADDR_WIDTH-1:0] destinationRegisterOut,
    output logic                      registerWriteEnableOut,
    output logic [1:0]                occupancy
);

    typedef struct packed {
        logic                      sel;
        logic [DATA_WIDTH-1:0]     mem;
        logic [DATA_WIDTH-1:0]     alu;
        logic [REG_ADDR_WIDTH-1:0] rd;
        logic                      we;
    } entry_t;

    entry_t main_q, main_d;
    entry_t skid_q, skid_d;
    entry_t in_entry;
    logic   main_valid_q, main_valid_d;
    logic   skid_valid_q, skid_valid_d;
    logic   in_ready_q;
    logic [1:0] occupancy_q;
    logic   accept;
    logic   release_head;

    assign accept       = inValid & in_ready_q;
    assign release_head = main_valid_q & outReady;

    // Pack the incoming entry; writes to x0 are dropped at capture.
    always_comb begin
        in_entry     = '0;
        in_entry.sel = writeBackFromMemoryOrAlu;
        in_entry.mem = memoryReadData;
        in_entry.alu = aluData;
        in_entry.rd  = destinationRegister;
        in_entry.we  = registerWriteEnable & (destinationRegister != '0);
    end

    // Next-state selection for the main and skid slots.
    always_comb begin
        main_d       = main_q;
        skid_d       = skid_q;
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;
        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!main_valid_q) begin
            if (accept) begin
                main_d       = in_entry;
                main_valid_d = 1'b1;
            end
        end else if (!skid_valid_q) begin
            if (accept && release_head) begin
                main_d = in_entry;
            end else if (accept) begin
                skid_d       = in_entry;
                skid_valid_d = 1'b1;
            end else if (release_head) begin
                main_valid_d = 1'b0;
            end
        end else if (release_head) begin
            main_d       = skid_q;
            skid_valid_d = 1'b0;
        end
    end

    // State registers; ready and occupancy derive from the next state.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            main_q       <= '0;
            skid_q       <= '0;
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b1;
            occupancy_q  <= 2'd0;
        end else begin
            main_q       <= main_d;
            skid_q       <= skid_d;
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            in_ready_q   <= ~skid_valid_d;
            occupancy_q  <= {1'b0, main_valid_d} + {1'b0, skid_valid_d};
        end
    end

    assign inReady                     = in_ready_q;
    assign occupancy                   = occupancy_q;
    assign outValid                    = main_valid_q;
    assign writeBackFromMemoryOrAluOut = main_q.sel;
    assign memoryReadDataOut           = main_q.mem;
    assign aluDataOut                  = main_q.alu;
    assign writeBackDataOut            = main_q.sel ? main_q.mem : main_q.alu;
    assign destinationRegisterOut      = main_q.rd;
    assign registerWriteEnableOut      = main_q.we & main_valid_q;

endmodule

// File: tb/tb_memory_writeback_skid_register.sv
// Directed + short random bench for memory_writeback_skid_register.
// Expected head entries live in a scoreboard queue.
module tb_memory_writeback_skid_register;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          clock;
    logic          reset;
    logic          flush;
    logic          inValid;
    logic          inReady;
    logic          sel;
    logic [DW-1:0] mem;
    logic [DW-1:0] alu;
    logic [AW-1:0] rd;
    logic          we;
    logic          outValid;
    logic          outReady;
    logic          selOut;
    logic [DW-1:0] memOut;
    logic [DW-1:0] aluOut;
    logic [DW-1:0] wbOut;
    logic [AW-1:0] rdOut;
    logic          weOut;
    logic [1:0]    occupancy;

    typedef struct {
        logic          sel;
        logic [DW-1:0] mem;
        logic [DW-1:0] alu;
        logic [DW-1:0] wb;
        logic [AW-1:0] rd;
        logic          we;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;

    memory_writeback_skid_register #(
        .DATA_WIDTH(DW),
        .REG_ADDR_WIDTH(AW)
    ) dut (
        .clock(clock),
        .reset(reset),
        .flush(flush),
        .inValid(inValid),
        .inReady(inReady),
        .writeBackFromMemoryOrAlu(sel),
        .memoryReadData(mem),
        .aluData(alu),
        .destinationRegister(rd),
        .registerWriteEnable(we),
        .outValid(outValid),
        .outReady(outReady),
        .writeBackFromMemoryOrAluOut(selOut),
        .memoryReadDataOut(memOut),
        .aluDataOut(aluOut),
        .writeBackDataOut(wbOut),
        .destinationRegisterOut(rdOut),
        .registerWriteEnableOut(weOut),
        .occupancy(occupancy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_outValid"}, 64'(outValid), 64'd0);
        chk({tag, "_inReady"}, 64'(inReady), 64'd1);
        chk({tag, "_occ"}, 64'(occupancy), 64'd0);
        chk({tag, "_sel"}, 64'(selOut), 64'd0);
        chk({tag, "_mem"}, 64'(memOut), 64'd0);
        chk({tag, "_alu"}, 64'(aluOut), 64'd0);
        chk({tag, "_wb"}, 64'(wbOut), 64'd0);
        chk({tag, "_rd"}, 64'(rdOut), 64'd0);
        chk({tag, "_we"}, 64'(weOut), 64'd0);
    endtask

    // One clock: drive, check against scoreboard, update model, advance.
    task automatic cycle(input logic iv, input logic ordy, input logic fl,
                         input logic s, input logic [DW-1:0] m,
                         input logic [DW-1:0] a, input logic [AW-1:0] r,
                         input logic w);
        exp_t e;
        logic acc;
        logic rel;
        inValid  = iv;
        outReady = ordy;
        flush    = fl;
        sel      = s;
        mem      = m;
        alu      = a;
        rd       = r;
        we       = w;
        #1;
        chk("occupancy", 64'(occupancy), 64'(q.size()));
        chk("inReady", 64'(inReady), 64'(q.size() < 2));
        chk("outValid", 64'(outValid), 64'(q.size() != 0));
        if (q.size() != 0) begin
            chk("head_sel", 64'(selOut), 64'(q[0].sel));
            chk("head_mem", 64'(memOut), 64'(q[0].mem));
            chk("head_alu", 64'(aluOut), 64'(q[0].alu));
            chk("head_wb", 64'(wbOut), 64'(q[0].wb));
            chk("head_rd", 64'(rdOut), 64'(q[0].rd));
            chk("head_we", 64'(weOut), 64'(q[0].we));
        end else begin
            chk("idle_we", 64'(weOut), 64'd0);
        end
        acc = iv && (q.size() < 2);
        rel = (q.size() != 0) && ordy;
        if (fl) begin
            q.delete();
        end else begin
            if (rel) void'(q.pop_front());
            if (acc) begin
                e.sel = s;
                e.mem = m;
                e.alu = a;
                e.wb  = s ? m : a;
                e.rd  = r;
                e.we  = w && (r != 0);
                q.push_back(e);
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input logic ordy);
        cycle(1'b0, ordy, 1'b0, 1'b0, '0, '0, '0, 1'b0);
    endtask

    initial begin
        reset    = 1'b1;
        flush    = 1'b0;
        inValid  = 1'b0;
        outReady = 1'b0;
        sel      = 1'b0;
        mem      = '0;
        alu      = '0;
        rd       = '0;
        we       = 1'b0;
        #1 reset = 1'b0;

        // Reset held with random inputs.
        for (int i = 0; i < 3; i++) begin
            inValid  = 1'($urandom);
            outReady = 1'($urandom);
            flush    = 1'($urandom);
            sel      = 1'($urandom);
            mem      = $urandom;
            alu      = $urandom;
            rd       = 5'($urandom);
            we       = 1'($urandom);
            @(posedge clock);
            #1;
            chk_zero_outputs("reset");
        end
        reset = 1'b1;
        idle(1'b1);
        idle(1'b0);
        chk_zero_outputs("post_reset");

        // Passthrough and back-to-back stream.
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 32'hA5A5_0000, 32'h0000_1234,
              5'd5, 1'b1);
        chk("pass_wb", 64'(wbOut), 64'h1234);
        chk("pass_rd", 64'(rdOut), 64'd5);
        chk("pass_we", 64'(weOut), 64'd1);
        for (int i = 0; i < 10; i++)
            cycle(1'b1, 1'b1, 1'b0, 1'(i), 32'h1000 + 32'(i),
                  32'h2000 + 32'(i), 5'(i + 1), 1'b1);
        idle(1'b1);
        idle(1'b1);

        // Stall fill, then drain.
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF, 32'h1111_1111,
              5'd10, 1'b1);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h2222_2222, 32'h0BBB_0BBB,
              5'd11, 1'b1);
        chk("stall_wb", 64'(wbOut), 64'hDEAD_BEEF);
        chk("stall_occ", 64'(occupancy), 64'd2);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h3333_3333, 32'h4444_4444,
              5'd12, 1'b1);
        idle(1'b1);
        chk("drain_b_wb", 64'(wbOut), 64'h0BBB_0BBB);
        chk("drain_ready", 64'(inReady), 64'd1);
        idle(1'b1);
        idle(1'b1);

        // x0 suppression.
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'd7, 5'd0, 1'b1);
        chk("x0_we", 64'(weOut), 64'd0);
        chk("x0_wb", 64'(wbOut), 64'd7);
        idle(1'b1);
        idle(1'b1);

        // Flush with a full buffer and a concurrent input.
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'hAAAA_0001, 5'd1, 1'b1);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'hAAAA_0002, 5'd2, 1'b1);
        cycle(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 32'hBAD0_BAD0, 5'd3, 1'b1);
        chk("flush_occ", 64'(occupancy), 64'd0);
        chk("flush_valid", 64'(outValid), 64'd0);
        idle(1'b1);
        idle(1'b1);

        // Short random traffic.
        for (int i = 0; i < 60; i++)
            cycle(1'($urandom), 1'($urandom), 1'($urandom_range(0, 15) == 0),
                  1'($urandom), $urandom, $urandom, 5'($urandom),
                  1'($urandom));
        for (int i = 0; i < 3; i++) idle(1'b1);

        // Async reset in the middle of a stall.
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 32'hCAFE_0001, 32'h1, 5'd4, 1'b1);
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 32'hCAFE_0002, 32'h2, 5'd6, 1'b1);
        inValid = 1'b0;
        chk("pre_areset_occ", 64'(occupancy), 64'd2);
        #1 reset = 1'b0;
        #1;
        chk_zero_outputs("areset");
        q.delete();
        #1 reset = 1'b1;
        @(posedge clock);
        #1;
        idle(1'b1);
        idle(1'b1);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
